alu_result_decoder: RTL and testbench

- Sequential decoder that takes an 8-bit result produced by the team's ALU, together with that operation's 3-bit select code.
- Interprets the result in the number format implied by the select code: 2's complement, 1's complement, sign-magnitude, or raw unsigned for logic ops.
- Produces a sign flag, an 8-bit magnitude and a 3-digit BCD magnitude using a multi-cycle shift-add-3 (double-dabble) conversion.
- Sits between the ALU output and the display/readback path; uses a start/busy/done handshake.

---
 rtl/alu_result_decoder_if.sv | 29 ++
 rtl/alu_result_decoder.sv | 143 ++++++++++++++
 tb/tb_alu_result_decoder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_decoder_if.sv
// Handshake and result bundle between the ALU readback path and
// the result decoder.
interface alu_result_decoder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       sel;
    logic [WIDTH-1:0] res;
    logic             busy;
    logic             done;
    logic             sign;
    logic             neg_zero;
    logic [WIDTH-1:0] mag;
    logic [3:0]       bcd_hund;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;

    modport master (
        output start, sel, res,
        input  busy, done, sign, neg_zero, mag,
        input  bcd_hund, bcd_tens, bcd_ones
    );

    modport slave (
        input  start, sel, res,
        output busy, done, sign, neg_zero, mag,
        output bcd_hund, bcd_tens, bcd_ones
    );
endinterface

// File: rtl/alu_result_decoder.sv
// Decodes an ALU result by its number format into sign, magnitude
// and 3-digit BCD using an 8-cycle double-dabble conversion.
module alu_result_decoder #(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 nrst,
    alu_result_decoder_if.slave bus
);
    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [2:0]       cnt;
    logic [WIDTH-1:0] sr;
    logic [11:0]      acc;
    logic             p_sign;
    logic             p_nz;
    logic [WIDTH-1:0] p_mag;

    logic             busy_q;
    logic             done_q;
    logic             sign_q;
    logic             nz_q;
    logic [WIDTH-1:0] mag_q;
    logic [11:0]      bcd_q;

    logic             d_sign;
    logic             d_nz;
    logic [WIDTH-1:0] d_mag;
    logic [11:0]      adj;
    logic [11:0]      acc_n;
    logic [WIDTH-1:0] sr_n;
    logic             last;

    function automatic logic [3:0] fix(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    always_comb begin
        d_sign = bus.res[WIDTH-1];
        d_nz   = 1'b0;
        d_mag  = bus.res;
        unique case (bus.sel)
            3'b000, 3'b001: begin
                if (bus.res[WIDTH-1])
                    d_mag = ~bus.res + 1'b1;
            end
            3'b010, 3'b011: begin
                if (bus.res[WIDTH-1])
                    d_mag = ~bus.res;
                d_nz = &bus.res;
            end
            3'b100, 3'b101: begin
                d_mag = {1'b0, bus.res[WIDTH-2:0]};
                d_nz  = bus.res[WIDTH-1]
                      & ~|bus.res[WIDTH-2:0];
            end
            3'b110, 3'b111: begin
                d_sign = 1'b0;
            end
        endcase
    end

    // Add-3 precedes the shift, so the final shift is never corrected.
    always_comb begin
        adj = {fix(acc[11:8]), fix(acc[7:4]), fix(acc[3:0])};
        {acc_n, sr_n} = {adj, sr} << 1;
        last = (cnt == 3'd7);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.start) state_n = CONV;
            CONV: if (last) state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt    <= '0;
            sr     <= '0;
            acc    <= '0;
            p_sign <= 1'b0;
            p_nz   <= 1'b0;
            p_mag  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sign_q <= 1'b0;
            nz_q   <= 1'b0;
            mag_q  <= '0;
            bcd_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sr     <= d_mag;
                        acc    <= '0;
                        cnt    <= '0;
                        p_sign <= d_sign;
                        p_nz   <= d_nz;
                        p_mag  <= d_mag;
                        busy_q <= 1'b1;
                    end
                end
                CONV: begin
                    sr  <= sr_n;
                    acc <= acc_n;
                    cnt <= cnt + 3'd1;
                    if (last) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        sign_q <= p_sign;
                        nz_q   <= p_nz;
                        mag_q  <= p_mag;
                        bcd_q  <= acc_n;
                    end
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sign     = sign_q;
    assign bus.neg_zero = nz_q;
    assign bus.mag      = mag_q;
    assign bus.bcd_hund = bcd_q[11:8];
    assign bus.bcd_tens = bcd_q[7:4];
    assign bus.bcd_ones = bcd_q[3:0];
endmodule

// File: tb/tb_alu_result_decoder.sv
// Self-checking bench: value-level model compared every cycle plus
// hand-computed literal results for the directed vectors.
module tb_alu_result_decoder;
    logic clk;
    logic nrst;
    int   checks;
    int   errors;

    alu_result_decoder_if #(.WIDTH(8)) bus ();

    alu_result_decoder #(.WIDTH(8)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       m_busy;
    logic       m_done;
    int         m_left;
    logic       m_sign;
    logic       m_nz;
    int         m_mag;
    logic       p_sign;
    logic       p_nz;
    int         p_mag;

    task automatic chk(input string name, input int got,
                       input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Interpret the result as a signed value, then take |value|.
    task automatic decode(input logic [2:0] s,
                          input logic [7:0] r,
                          output logic sg, output logic nz,
                          output int mg);
        int v;
        int u;
        u  = int'(r);
        nz = 1'b0;
        case (s[2:1])
            2'd0: v = (u > 127) ? u - 256 : u;
            2'd1: begin
                v  = (u > 127) ? -(255 - u) : u;
                nz = (u == 255);
            end
            2'd2: begin
                v  = (u > 127) ? -(u - 128) : u;
                nz = (u == 128);
            end
            default: v = u;
        endcase
        sg = (v < 0) || nz;
        mg = (v < 0) ? -v : v;
    endtask

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_sign <= 1'b0;
            m_nz   <= 1'b0;
            m_mag  <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (bus.start) begin
                    decode(bus.sel, bus.res, p_sign, p_nz, p_mag);
                    m_busy <= 1'b1;
                    m_left <= 8;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_sign <= p_sign;
                    m_nz   <= p_nz;
                    m_mag  <= p_mag;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(bus.busy), int'(m_busy));
        chk("done", int'(bus.done), int'(m_done));
        chk("sign", int'(bus.sign), int'(m_sign));
        chk("neg_zero", int'(bus.neg_zero), int'(m_nz));
        chk("mag", int'(bus.mag), m_mag);
        chk("hund", int'(bus.bcd_hund), m_mag / 100);
        chk("tens", int'(bus.bcd_tens), (m_mag / 10) % 10);
        chk("ones", int'(bus.bcd_ones), m_mag % 10);
    end

    task automatic go(input logic [2:0] s, input logic [7:0] r);
        @(negedge clk);
        bus.sel   = s;
        bus.res   = r;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 1;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            errors++;
            $display("FAIL %s timeout waiting for done", name);
        end
    endtask

    task automatic expect_out(input string name, input int sg,
                              input int nz, input int mg,
                              input int h, input int t,
                              input int o);
        chk({name, ".sign"}, int'(bus.sign), sg);
        chk({name, ".nz"}, int'(bus.neg_zero), nz);
        chk({name, ".mag"}, int'(bus.mag), mg);
        chk({name, ".bcd"},
            int'({bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}),
            (h << 8) | (t << 4) | o);
    endtask

    int n;

    initial begin
        checks    = 0;
        errors    = 0;
        nrst      = 1'b0;
        bus.start = 1'b0;
        bus.sel   = 3'b000;
        bus.res   = 8'h00;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle.busy", int'(bus.busy), 0);
        expect_out("idle", 0, 0, 0, 0, 0, 0);

        go(3'b000, 8'h80);
        chk("tc80.busy", int'(bus.busy), 1);
        wait_done("tc80", n);
        chk("tc80.latency", n, 9);
        chk("tc80.busy_end", int'(bus.busy), 0);
        expect_out("tc80", 1, 0, 128, 1, 2, 8);
        @(negedge clk);
        chk("tc80.pulse", int'(bus.done), 0);

        go(3'b010, 8'hFF);
        wait_done("oc_ff", n);
        expect_out("oc_ff", 1, 1, 0, 0, 0, 0);

        go(3'b011, 8'hF9);
        wait_done("oc_f9", n);
        expect_out("oc_f9", 1, 0, 6, 0, 0, 6);

        go(3'b100, 8'hD5);
        wait_done("sm_d5", n);
        expect_out("sm_d5", 1, 0, 85, 0, 8, 5);

        go(3'b110, 8'hFF);
        wait_done("lg_ff", n);
        expect_out("lg_ff", 0, 0, 255, 2, 5, 5);

        go(3'b001, 8'h63);
        @(negedge clk);
        chk("ign.hold", int'(bus.mag), 255);
        @(negedge clk);
        bus.res   = 8'h01;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ign", n);
        expect_out("ign", 0, 0, 99, 0, 9, 9);

        bus.sel   = 3'b000;
        bus.res   = 8'h85;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("b2b", n);
        chk("b2b.latency", n, 9);
        expect_out("b2b", 1, 0, 123, 1, 2, 3);

        go(3'b111, 8'hC8);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        chk("rst.busy", int'(bus.busy), 0);
        chk("rst.done", int'(bus.done), 0);
        expect_out("rst", 0, 0, 0, 0, 0, 0);
        repeat (12) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.still_zero", int'(bus.mag), 0);

        go(3'b111, 8'hC8);
        wait_done("lg_c8", n);
        chk("lg_c8.latency", n, 9);
        expect_out("lg_c8", 0, 0, 200, 2, 0, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
